// File: rtl/usb_nrzi_tx.sv
// USB transmit serializer: SYNC, LSB-first payload with bit stuffing, NRZI line coding and EOP.
// Define USB_TX_UNDERRUN_EN to add the tx_underrun port and the bit-stuff-error abort on underrun.
module usb_nrzi_tx #(
  parameter int LOW_SPEED = 0
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       bit_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
`ifdef USB_TX_UNDERRUN_EN
  output logic       tx_underrun,
`endif
  output logic       usb_dp,
  output logic       usb_dm,
  output logic       usb_oe,
  output logic       busy
);

  localparam logic J_DP = (LOW_SPEED == 0) ? 1'b1 : 1'b0;
  localparam logic J_DM = (LOW_SPEED == 0) ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_ABORT   = 3'd4,
    ST_EOP_SE0 = 3'd5,
    ST_EOP_J   = 3'd6
  } state_t;

  logic [2:0] bit_sync_r;
  logic       bit_tick_s;
  state_t     state_r, state_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [2:0] ones_cnt_r, ones_cnt_s;
  logic [7:0] shift_r, shift_s;
  logic       last_r, last_s;
  logic       line_r, line_s;        // NRZI level, 1 = J
  logic       se0_s;
  logic       oe_s, busy_s;
  logic       load_s, end_s, underrun_s, abort_s, fin_s;
  logic       dp_r, dm_r, oe_r, busy_r;

  // bit_clk synchronizer plus rising-edge detector
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      bit_sync_r <= 3'b000;
    end else begin
      bit_sync_r <= {bit_sync_r[1:0], bit_clk};
    end
  end

  assign bit_tick_s = bit_sync_r[1] & ~bit_sync_r[2];

  // Next-state and line symbol for the upcoming bit_tick; state names the symbol to emit next
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    ones_cnt_s = ones_cnt_r;
    shift_s    = shift_r;
    last_s     = last_r;
    line_s     = line_r;
    se0_s      = 1'b0;
    oe_s       = 1'b1;
    busy_s     = 1'b1;
    load_s     = 1'b0;
    end_s      = 1'b0;
    underrun_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ones_cnt_s = 3'd0;
        bit_cnt_s  = 3'd1;
        if (tx_valid) begin
          line_s  = 1'b0;            // first SYNC bit is a 0: J -> K
          state_s = ST_SYNC;
        end else begin
          line_s = 1'b1;
          oe_s   = 1'b0;
          busy_s = 1'b0;
        end
      end
      ST_SYNC: begin
        if (bit_cnt_r == 3'd7) begin
          ones_cnt_s = ones_cnt_r + 3'd1;
          load_s     = tx_valid;
          underrun_s = ~tx_valid;
          state_s    = ST_DATA;
          bit_cnt_s  = 3'd0;
        end else begin
          line_s     = ~line_r;
          ones_cnt_s = 3'd0;
          bit_cnt_s  = bit_cnt_r + 3'd1;
        end
      end
      ST_DATA: begin
        if (ones_cnt_r == 3'd6) begin
          line_s     = ~line_r;
          ones_cnt_s = 3'd0;
        end else begin
          shift_s    = {1'b0, shift_r[7:1]};
          line_s     = shift_r[0] ? line_r : ~line_r;
          ones_cnt_s = shift_r[0] ? (ones_cnt_r + 3'd1) : 3'd0;
          if (bit_cnt_r == 3'd7) begin
            end_s      = last_r;
            load_s     = ~last_r & tx_valid;
            underrun_s = ~last_r & ~tx_valid;
            bit_cnt_s  = 3'd0;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
      end
      ST_STUFF: begin
        line_s     = ~line_r;
        ones_cnt_s = 3'd0;
        bit_cnt_s  = 3'd0;
        state_s    = ST_EOP_SE0;
      end
      ST_ABORT: begin
        ones_cnt_s = 3'd0;
        if (bit_cnt_r == 3'd6) begin
          bit_cnt_s = 3'd0;
          state_s   = ST_EOP_SE0;
        end else begin
          bit_cnt_s = bit_cnt_r + 3'd1;
        end
      end
      ST_EOP_SE0: begin
        se0_s  = 1'b1;
        line_s = 1'b1;
        if (bit_cnt_r == 3'd1) begin
          state_s = ST_EOP_J;
        end else begin
          bit_cnt_s = bit_cnt_r + 3'd1;
        end
      end
      ST_EOP_J: begin
        line_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        line_s  = 1'b1;
        oe_s    = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase

`ifdef USB_TX_UNDERRUN_EN
    abort_s = underrun_s;
    fin_s   = end_s;
`else
    abort_s = 1'b0;
    fin_s   = end_s | underrun_s;
`endif

    if (abort_s) begin
      state_s   = ST_ABORT;
      bit_cnt_s = 3'd0;
    end else if (fin_s) begin
      // a stuff bit still owed after the final data bit goes out before SE0
      state_s   = (ones_cnt_s == 3'd6) ? ST_STUFF : ST_EOP_SE0;
      bit_cnt_s = 3'd0;
    end else begin
      shift_s = load_s ? tx_data : shift_s;
      last_s  = load_s ? tx_last : last_s;
    end
  end

  assign tx_ready = bit_tick_s & load_s;

  // State and registered pad outputs, advanced once per bit_tick
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      ones_cnt_r <= 3'd0;
      shift_r    <= 8'h00;
      last_r     <= 1'b0;
      line_r     <= 1'b1;
      dp_r       <= J_DP;
      dm_r       <= J_DM;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else if (bit_tick_s) begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      ones_cnt_r <= ones_cnt_s;
      shift_r    <= shift_s;
      last_r     <= last_s;
      line_r     <= line_s;
      dp_r       <= se0_s ? 1'b0 : (line_s ? J_DP : J_DM);
      dm_r       <= se0_s ? 1'b0 : (line_s ? J_DM : J_DP);
      oe_r       <= oe_s;
      busy_r     <= busy_s;
    end
  end

  assign usb_dp = dp_r;
  assign usb_dm = dm_r;
  assign usb_oe = oe_r;
  assign busy   = busy_r;

`ifdef USB_TX_UNDERRUN_EN
  logic underrun_r;

  // One-cycle pulse on the tick that emits the first abort bit
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= bit_tick_s && (state_r == ST_ABORT) && (bit_cnt_r == 3'd0);
    end
  end

  assign tx_underrun = underrun_r;
`endif

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Scoreboard bench for usb_nrzi_tx: full-speed and low-speed instances share stimulus,
// a line-level model queues expected symbols per bit_tick and the monitor pops and compares them.
module tb_usb_nrzi_tx;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic       bit_clk  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last  = 1'b0;
  logic       fs_ready, fs_dp, fs_dm, fs_oe, fs_busy;
  logic       ls_ready, ls_dp, ls_dm, ls_oe, ls_busy;
`ifdef USB_TX_UNDERRUN_EN
  logic       fs_underrun, ls_underrun;
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  usb_nrzi_tx #(.LOW_SPEED(0)) u_fs (
    .clock_in(clock_in), .reset_n(reset_n), .bit_clk(bit_clk),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(fs_ready),
`ifdef USB_TX_UNDERRUN_EN
    .tx_underrun(fs_underrun),
`endif
    .usb_dp(fs_dp), .usb_dm(fs_dm), .usb_oe(fs_oe), .busy(fs_busy)
  );

  usb_nrzi_tx #(.LOW_SPEED(1)) u_ls (
    .clock_in(clock_in), .reset_n(reset_n), .bit_clk(bit_clk),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(ls_ready),
`ifdef USB_TX_UNDERRUN_EN
    .tx_underrun(ls_underrun),
`endif
    .usb_dp(ls_dp), .usb_dm(ls_dm), .usb_oe(ls_oe), .busy(ls_busy)
  );

  always #5 clock_in = ~clock_in;

  // bit clock = clock_in / 5, edges kept clear of clock_in edges
  initial begin
    #2;
    forever begin
      bit_clk = 1'b1;
      #20;
      bit_clk = 1'b0;
      #30;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected symbols {ready_on_this_tick, sym}: sym 0 = SE0, 1 = J, 2 = K
  logic [2:0] exp_q[$];
  logic [7:0] pkt[4];
  logic       m_line;
  int         m_ones;

  task automatic m_push(input logic [1:0] sym);
    exp_q.push_back({1'b0, sym});
  endtask

  task automatic m_push_line();
    m_push(m_line ? 2'd1 : 2'd2);
  endtask

  task automatic m_mark_ready();
    logic [2:0] t;
    t = exp_q.pop_back();
    t[2] = 1'b1;
    exp_q.push_back(t);
  endtask

  task automatic m_bit(input logic b);
    if (m_ones == 6) begin
      m_line = ~m_line;
      m_ones = 0;
      m_push_line();
    end
    if (b) begin
      m_ones++;
    end else begin
      m_line = ~m_line;
      m_ones = 0;
    end
    m_push_line();
  endtask

  task automatic m_packet(input int n, input bit underrun);
    m_line = 1'b1;
    m_ones = 0;
    for (int i = 0; i < 8; i++) m_bit(i == 7);
    m_mark_ready();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) m_bit(pkt[k][i]);
      if (k < n - 1) m_mark_ready();
    end
    if (underrun && ABORT_EN) begin
      for (int i = 0; i < 7; i++) m_push_line();
    end else if (m_ones == 6) begin
      m_line = ~m_line;
      m_push_line();
    end
    m_push(2'd0);
    m_push(2'd0);
    m_push(2'd1);
  endtask

  // monitor: mirrors the bit_clk synchronizer to know when a tick edge occurs
  logic [2:0] sy       = 3'b000;
  logic       rdy_neg  = 1'b0;
  logic       lrdy_neg = 1'b0;
  bit         mon_en   = 1'b1;
  bit         started  = 1'b0;
  int         tick_cnt = 0;
  int         oe_ticks = 0;
  int         rdy_cnt  = 0;
  int         und_cnt  = 0;

  always @(negedge clock_in) begin
    rdy_neg  <= fs_ready;
    lrdy_neg <= ls_ready;
  end

  initial begin : monitor
    logic       tk;
    logic [2:0] e;
    forever begin
      @(posedge clock_in);
      tk = sy[1] & ~sy[2];
      sy = reset_n ? {sy[1:0], bit_clk} : 3'b000;
      #1;
      if (rdy_neg) rdy_cnt++;
      if (rdy_neg && !tk) check_eq("ready_offtick", rdy_neg, 1'b0);
`ifdef USB_TX_UNDERRUN_EN
      if (fs_underrun) und_cnt++;
`endif
      if (reset_n && tk) begin
        tick_cnt++;
        if (fs_oe) oe_ticks++;
        if (mon_en && exp_q.size() != 0 && (fs_oe || started)) begin
          started = 1'b1;
          e = exp_q.pop_front();
          check_eq("fs_dp", fs_dp, e[1:0] == 2'd1);
          check_eq("fs_dm", fs_dm, e[1:0] == 2'd2);
          check_eq("fs_oe", fs_oe, 1'b1);
          check_eq("fs_busy", fs_busy, 1'b1);
          check_eq("ls_dp", ls_dp, e[1:0] == 2'd2);
          check_eq("ls_dm", ls_dm, e[1:0] == 2'd1);
          check_eq("ls_oe", ls_oe, 1'b1);
          check_eq("fs_ready", rdy_neg, e[2]);
          check_eq("ls_ready", lrdy_neg, e[2]);
          if (exp_q.size() == 0) started = 1'b0;
        end else if (mon_en && exp_q.size() == 0) begin
          check_eq("idle_oe", fs_oe, 1'b0);
          check_eq("idle_busy", fs_busy, 1'b0);
          check_eq("idle_dp", fs_dp, 1'b1);
          check_eq("idle_ls_dm", ls_dm, 1'b1);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_cnt + n;
    guard  = 0;
    while (tick_cnt < target && guard < n * 10 + 50) begin
      @(posedge clock_in);
      #2;
      guard++;
    end
  endtask

  task automatic send_pkt(input int n, input bit underrun);
    int guard;
    m_packet(n, underrun);
    tx_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      tx_data = pkt[k];
      tx_last = (k == n - 1) && !underrun;
      guard = 0;
      do begin
        @(negedge clock_in);
        guard++;
      end while (!fs_ready && guard < 500);
      check_eq("accept_wait", fs_ready, 1'b1);
      @(posedge clock_in);
      #2;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clock_in);
      guard++;
    end
    check_eq("pkt_drain", exp_q.size(), 0);
    exp_q.delete();
    started = 1'b0;
    wait_ticks(2);
  endtask

  initial begin : stimulus
    int oe0, rdy0, und0, guard;

    #12;
    check_eq("rst_fs_dp", fs_dp, 1'b1);
    check_eq("rst_fs_dm", fs_dm, 1'b0);
    check_eq("rst_fs_oe", fs_oe, 1'b0);
    check_eq("rst_busy", fs_busy, 1'b0);
    check_eq("rst_ready", fs_ready, 1'b0);
    check_eq("rst_ls_dp", ls_dp, 1'b0);
    check_eq("rst_ls_dm", ls_dm, 1'b1);
    repeat (3) @(posedge clock_in);
    #2 reset_n = 1'b1;
    wait_ticks(3);

    // single 0x00 byte
    pkt[0] = 8'h00;
    oe0 = oe_ticks; rdy0 = rdy_cnt;
    send_pkt(1, 1'b0);
    check_eq("b00_oe_ticks", oe_ticks - oe0, 19);
    check_eq("b00_ready_cnt", rdy_cnt - rdy0, 1);

    // 0xFF forces one stuffed bit
    pkt[0] = 8'hFF;
    oe0 = oe_ticks;
    send_pkt(1, 1'b0);
    check_eq("bff_oe_ticks", oe_ticks - oe0, 20);

    // two bytes, tx_valid held
    pkt[0] = 8'hA5; pkt[1] = 8'h3C;
    rdy0 = rdy_cnt;
    send_pkt(2, 1'b0);
    check_eq("two_ready_cnt", rdy_cnt - rdy0, 2);

    // reset while a stuff bit is pending mid-payload
    mon_en   = 1'b0;
    tx_data  = 8'hFF;
    tx_last  = 1'b0;
    tx_valid = 1'b1;
    guard = 0;
    do begin
      @(posedge clock_in);
      #2;
      guard++;
    end while (!fs_oe && guard < 500);
    check_eq("rst_pkt_start", fs_oe, 1'b1);
    wait_ticks(12);
    #3 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_dp", fs_dp, 1'b1);
    check_eq("mid_rst_dm", fs_dm, 1'b0);
    check_eq("mid_rst_oe", fs_oe, 1'b0);
    check_eq("mid_rst_busy", fs_busy, 1'b0);
    check_eq("mid_rst_ls_dp", ls_dp, 1'b0);
    check_eq("mid_rst_ls_dm", ls_dm, 1'b1);
    tx_valid = 1'b0;
    repeat (3) @(posedge clock_in);
    #2 reset_n = 1'b1;
    exp_q.delete();
    started = 1'b0;
    mon_en  = 1'b1;
    wait_ticks(2);
    pkt[0] = 8'h00;
    send_pkt(1, 1'b0);

    // underrun after 0x01
    pkt[0] = 8'h01;
    oe0 = oe_ticks; und0 = und_cnt;
    send_pkt(1, 1'b1);
    check_eq("und_oe_ticks", oe_ticks - oe0, ABORT_EN ? 26 : 19);
`ifdef USB_TX_UNDERRUN_EN
    check_eq("und_pulse_cnt", und_cnt - und0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/usb_nrzi_tx.md
Name: usb_nrzi_tx

Overview:
- USB transmit serializer that consumes the divided bit clock produced by the clock divider (DIVISOR set to the bit period, e.g. 48 MHz / 4 = 12 Mb/s).
- Accepts bytes over a valid/ready stream and sends a complete packet: SYNC, payload LSB-first with bit stuffing, NRZI encoding, then EOP.
- Drives the D+/D- pad pair and output enable.
- Sits between the clock divider and the PHY pads; packet framing (PID, CRC) comes from upstream logic.

Parameters:
- LOW_SPEED, 0, 0 = full-speed polarity (J: dp=1, dm=0); 1 = low-speed polarity (J: dp=0, dm=1).

Ports:
- clock_in  input  1  system clock; all logic runs on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- bit_clk  input  1  divided bit clock from the clock divider; asynchronous to logic, always synchronized internally.
- tx_data  input  8  payload byte.
- tx_valid  input  1  tx_data valid.
- tx_last  input  1  qualifies tx_data as the final byte of the packet.
- tx_ready  output  1  byte accepted on this clock_in edge (combinational, high exactly one cycle per byte).
- usb_dp  output  1  D+ drive value.
- usb_dm  output  1  D- drive value.
- usb_oe  output  1  pad output enable.
- busy  output  1  packet in progress (SYNC through EOP J).

Behaviour:
- bit_clk synchronization: passed through 2 flops; a third flop gives rising-edge detect; bit_tick is a 1-cycle pulse.
- All line outputs are registered and update on the clock_in edge where bit_tick=1.
- Reset (async, any time including mid-packet): usb_dp/usb_dm = J, usb_oe=0, busy=0, tx_ready=0, stuff counter=0, state=IDLE. No partial EOP is sent.
- IDLE: oe=0, line = J. On bit_tick with tx_valid=1:
  - enter SYNC; oe=1; busy=1;
  - drive the first SYNC bit.
  - tx_data is not consumed here.
- SYNC: raw bits 0,0,0,0,0,0,0,1 (0x80 LSB-first), one per bit_tick.
  - On the tick that emits the 8th bit, sample tx_data with tx_ready=1.
  - Continue to DATA.
- DATA: shift the byte LSB-first, one raw bit per bit_tick. On the tick emitting bit 7:
  - if the current byte had tx_last=1, go to EOP_SE0 (after any pending stuff bit);
  - else if tx_valid=1, load the next byte (tx_ready=1);
  - else underrun (see optional feature).
- NRZI: raw 0 toggles the line between J and K; raw 1 holds it. Line state is J on entry to SYNC.
- Bit stuffing:
  - Ones counter runs from SYNC bit 0 onward and resets on any transmitted 0.
  - After 6 consecutive 1s, the next bit_tick sends a stuffed 0 (line toggles) and consumes no data bit.
  - A stuff bit due after the last data bit is sent before EOP.
  - tx_ready timing shifts by one tick whenever a stuff bit is inserted.
- EOP_SE0: dp=dm=0 for 2 bit_ticks, oe=1.
- EOP_J: line = J for 1 bit_tick.
- After EOP_J: IDLE; oe=0 and busy=0 on the next bit_tick edge.
- Back-to-back packets: tx_valid asserted during EOP starts the next SYNC no earlier than the first bit_tick after returning to IDLE.
- tx_valid/tx_data outside the load cycle are ignored. tx_ready is never asserted without tx_valid.

Optional Feature:
- Macro: USB_TX_UNDERRUN_EN.
- Defined:
  - adds output port tx_underrun (1 bit, reset 0).
  - On underrun, the block sends 7 raw 1s with stuffing suppressed (bit-stuff-error abort), then the normal EOP.
  - tx_underrun pulses high for one clock_in cycle on the tick of the first abort bit.
- Not defined:
  - no tx_underrun port.
  - Underrun is treated as end of packet: the pending stuff bit (if any) is sent, then the normal EOP.

Test Plan:
- Single byte 0x00 with tx_last, DIVISOR=5, full speed:
  - line per bit = K J K J K J K K, then J K J K J K J K, then SE0 SE0 J.
  - oe=1 for 19 bit_ticks; tx_ready pulses once.
- Byte 0xFF with tx_last:
  - after SYNC, 5 held bits, then one stuffed toggle, then 3 held bits, then EOP.
  - 20 bit_ticks total.
- Two bytes 0xA5, 0x3C, tx_valid held high:
  - tx_ready pulses exactly at the SYNC-bit-7 and byte0-bit-7 ticks.
  - Decoded NRZI stream (destuffed) equals 0x80, 0xA5, 0x3C.
- LOW_SPEED=1, byte 0x00: identical sequence with dp/dm swapped; SE0 unchanged.
- reset_n deasserted mid-payload: outputs immediately go to J/oe=0/busy=0. After release, a new packet starts with a clean SYNC and stuff count 0.
- Underrun: drop tx_valid after byte 0x01 (no tx_last).
  - USB_TX_UNDERRUN_EN defined: 7 held bits, then SE0 SE0 J, with a tx_underrun pulse.
  - USB_TX_UNDERRUN_EN not defined: SE0 SE0 J immediately after bit 7.
